// File: rtl/mul_error_sweeper.sv
// Sweeps every operand pair into an external approximate multiplier and
// accumulates error statistics against the exact product.
module mul_error_sweeper #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic [WIDTH-1:0]       mul_in1,
  output logic [WIDTH-1:0]       mul_in2,
  input  logic [2*WIDTH-2:0]     mul_out,
  input  logic                   mul_overflow,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH:0]       sample_cnt,
  output logic [2*WIDTH:0]       err_cnt,
  output logic [2*WIDTH-1:0]     max_ed,
  output logic [ACC_WIDTH-1:0]   sum_ed
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = 2 * WIDTH + 1;
  localparam logic [PW-1:0] IDX_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  if (ACC_WIDTH < 4 * WIDTH) begin : g_acc_width_check
    $error("mul_error_sweeper: ACC_WIDTH must be at least 4*WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  busy_next_s;
  logic                  done_next_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  start_ok_s;
  logic [PW-1:0]         idx_r;
  logic                  op_valid_r;
  logic                  s1_valid_r;
  logic [PW-1:0]         approx_r;
  logic [PW-1:0]         exact_r;
  logic [PW-1:0]         exact_s;
  logic [PW-1:0]         ed_s;
  logic [CW-1:0]         sample_cnt_r;
  logic [CW-1:0]         err_cnt_r;
  logic [PW-1:0]         max_ed_r;
  logic [ACC_WIDTH-1:0]  sum_ed_r;

  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

  assign start_ok_s = start && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign exact_s    = PW'(idx_r[WIDTH-1:0]) * PW'(idx_r[PW-1:WIDTH]);
  assign ed_s       = abs_diff(approx_r, exact_r);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; abort overrides everything, start only counts when idle or done
  always_comb begin
    state_next_s = state_r;
    if (abort) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = start ? ST_SWEEP : ST_IDLE;
        ST_SWEEP: state_next_s = (&idx_r) ? ST_DRAIN : ST_SWEEP;
        ST_DRAIN: state_next_s = ST_DONE;
        ST_DONE:  state_next_s = start ? ST_SWEEP : ST_DONE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // Status decode from the upcoming state so busy/done come straight from flops
  always_comb begin
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    case (state_next_s)
      ST_SWEEP: busy_next_s = 1'b1;
      ST_DRAIN: busy_next_s = 1'b1;
      ST_DONE:  done_next_s = 1'b1;
      default: begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
      end
    endcase
  end

  // Status output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
    end
  end

  // Operand index, two-stage compare pipeline and statistics accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r        <= {PW{1'b0}};
      op_valid_r   <= 1'b0;
      s1_valid_r   <= 1'b0;
      approx_r     <= {PW{1'b0}};
      exact_r      <= {PW{1'b0}};
      sample_cnt_r <= {CW{1'b0}};
      err_cnt_r    <= {CW{1'b0}};
      max_ed_r     <= {PW{1'b0}};
      sum_ed_r     <= {ACC_WIDTH{1'b0}};
    end else if (abort) begin
      // statistics stay frozen; the sample in flight is dropped
      idx_r      <= {PW{1'b0}};
      op_valid_r <= 1'b0;
      s1_valid_r <= 1'b0;
    end else if (start_ok_s) begin
      idx_r        <= {PW{1'b0}};
      op_valid_r   <= 1'b1;
      s1_valid_r   <= 1'b0;
      sample_cnt_r <= {CW{1'b0}};
      err_cnt_r    <= {CW{1'b0}};
      max_ed_r     <= {PW{1'b0}};
      sum_ed_r     <= {ACC_WIDTH{1'b0}};
    end else begin
      if (op_valid_r) begin
        if (&idx_r) begin
          op_valid_r <= 1'b0;
        end else begin
          idx_r <= idx_r + IDX_ONE;
        end
        approx_r <= {mul_overflow, mul_out};
        exact_r  <= exact_s;
      end
      s1_valid_r <= op_valid_r;
      if (s1_valid_r) begin
        sample_cnt_r <= sample_cnt_r + CNT_ONE;
        if (ed_s != {PW{1'b0}}) begin
          err_cnt_r <= err_cnt_r + CNT_ONE;
        end
        if (ed_s > max_ed_r) begin
          max_ed_r <= ed_s;
        end
        sum_ed_r <= sum_ed_r + ACC_WIDTH'(ed_s);
      end
    end
  end

  assign mul_in1    = idx_r[WIDTH-1:0];
  assign mul_in2    = idx_r[PW-1:WIDTH];
  assign busy       = busy_r;
  assign done       = done_r;
  assign sample_cnt = sample_cnt_r;
  assign err_cnt    = err_cnt_r;
  assign max_ed     = max_ed_r;
  assign sum_ed     = sum_ed_r;

endmodule

// File: tb/tb_mul_error_sweeper.sv
// Self-checking bench: drives the sweeper against several multiplier behaviours
// and compares every cycle with a cycle-count based statistics model.
module tb_mul_error_sweeper;

  localparam int W   = 5;
  localparam int AW  = 32;
  localparam int PW  = 2 * W;
  localparam int NA  = 1 << W;
  localparam int NP  = 1 << PW;
  localparam int AMX = NA - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [W-1:0]    mul_in1;
  logic [W-1:0]    mul_in2;
  logic [PW-2:0]   mul_out;
  logic            mul_overflow;
  logic            busy;
  logic            done;
  logic [PW:0]     sample_cnt;
  logic [PW:0]     err_cnt;
  logic [PW-1:0]   max_ed;
  logic [AW-1:0]   sum_ed;

  mul_error_sweeper #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_out(mul_out), .mul_overflow(mul_overflow),
    .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_ed(max_ed), .sum_ed(sum_ed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mode  = 0;   // 0 exact, 1 exact+1 at max pair, 2 constant zero, 3 random table
  logic [PW-1:0] rand_tab [NP];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint approx_val(input int a, input int b);
    case (mode)
      0: return longint'(a * b);
      1: return (a == AMX && b == AMX) ? longint'(a * b + 1) : longint'(a * b);
      2: return 0;
      default: return longint'(rand_tab[b * NA + a]);
    endcase
  endfunction

  function automatic longint ed_of(input int p);
    longint ex, ap;
    ex = longint'((p % NA) * (p / NA));
    ap = approx_val(p % NA, p / NA);
    return (ap > ex) ? ap - ex : ex - ap;
  endfunction

  // multiplier under test, as seen by the sweeper
  logic [PW-1:0] approx_s;
  always @(mul_in1, mul_in2, mode) approx_s = PW'(approx_val(int'(mul_in1), int'(mul_in2)));
  assign mul_out      = approx_s[PW-2:0];
  assign mul_overflow = approx_s[PW-1];

  // model: k counts edges since the start edge; after k edges, k-1 pairs are accumulated
  bit     m_running, m_done;
  int     m_k;
  longint m_n, m_err, m_max, m_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_running <= 1'b0; m_done <= 1'b0; m_k <= 0;
      m_n <= 0; m_err <= 0; m_max <= 0; m_sum <= 0;
    end else if (abort) begin
      m_running <= 1'b0; m_done <= 1'b0;
    end else if (start && !m_running) begin
      m_running <= 1'b1; m_done <= 1'b0; m_k <= 0;
      m_n <= 0; m_err <= 0; m_max <= 0; m_sum <= 0;
    end else if (m_running) begin
      m_k <= m_k + 1;
      if (m_k >= 1) begin
        m_n   <= m_n + 1;
        m_err <= m_err + ((ed_of(m_k - 1) != 0) ? 1 : 0);
        m_max <= (ed_of(m_k - 1) > m_max) ? ed_of(m_k - 1) : m_max;
        m_sum <= m_sum + ed_of(m_k - 1);
      end
      if (m_k == NP) begin
        m_running <= 1'b0; m_done <= 1'b1;
      end
    end
  end

  int exp_idx;
  always @(negedge clk) begin
    exp_idx = m_done ? NP - 1 : (m_running ? ((m_k > NP - 1) ? NP - 1 : m_k) : 0);
    check("busy", busy, m_running);
    check("done", done, m_done);
    check("mul_in1", mul_in1, exp_idx % NA);
    check("mul_in2", mul_in2, exp_idx / NA);
    check("sample_cnt", sample_cnt, m_n);
    check("err_cnt", err_cnt, m_err);
    check("max_ed", max_ed, m_max);
    check("sum_ed", sum_ed, m_sum);
  end

  task automatic run_sweep(input int pulse_at, input bit chk_order, output int busy_cycles);
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < NP + 200; i++) begin
      if (busy) busy_cycles++;
      if (done) break;
      if (chk_order && (i == 0 || i == 1 || i == NA || i == NP - 1)) begin
        check("order_in1", mul_in1, i % NA);
        check("order_in2", mul_in2, i / NA);
      end
      start = (i == pulse_at);
      @(negedge clk); #1;
    end
    start = 1'b0;
    check("done_reached", done, 1);
    check("busy_cycles", busy_cycles, NP + 1);
  endtask

  task automatic check_stats(input string tag, input longint n, input longint e,
                             input longint mx, input longint s);
    check({tag, "_samples"}, sample_cnt, n);
    check({tag, "_err"}, err_cnt, e);
    check({tag, "_max"}, max_ed, mx);
    check({tag, "_sum"}, sum_ed, s);
  endtask

  task automatic check_full_by_loop(input string tag);
    longint e, mx, s, d;
    e = 0; mx = 0; s = 0;
    for (int p = 0; p < NP; p++) begin
      d = ed_of(p);
      if (d != 0) e++;
      if (d > mx) mx = d;
      s += d;
    end
    check_stats(tag, NP, e, mx, s);
  endtask

  task automatic fill_random();
    mode = 0;
    for (int p = 0; p < NP; p++) begin
      if ($urandom_range(0, 2) == 0) rand_tab[p] = PW'((p % NA) * (p / NA));
      else rand_tab[p] = PW'($urandom_range(0, NP - 1));
    end
    mode = 3;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in1"}, mul_in1, 0);
    check({tag, "_in2"}, mul_in2, 0);
    check_stats(tag, 0, 0, 0, 0);
  endtask

  int bc;
  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk); #1 rst = 1'b0;

    mode = 0;
    run_sweep(-1, 1'b1, bc);
    check_stats("exact", NP, 0, 0, 0);

    mode = 1;
    run_sweep(-1, 1'b0, bc);
    check_stats("plus1", NP, 1, 1, 1);

    mode = 2;
    run_sweep(-1, 1'b0, bc);
    check_stats("zero", NP, 961, 961, 246016);

    // abort raised during cycle 100 together with start
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (99) @(negedge clk);
    #1 begin abort = 1'b1; start = 1'b1; end
    @(negedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_in1", mul_in1, 0);
    check("abort_in2", mul_in2, 0);
    check_stats("abort", 98, 63, 62, 1491);
    abort = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("abort_frozen", sample_cnt, 98);
    run_sweep(-1, 1'b0, bc);
    check_stats("after_abort", NP, 961, 961, 246016);

    // random multiplier with a stray start pulse mid-sweep
    fill_random();
    run_sweep($urandom_range(5, 900), 1'b0, bc);
    check_full_by_loop("rand1");

    // asynchronous reset between edges in the middle of a sweep
    mode = 2;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat ($urandom_range(20, 500)) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk); #1 rst = 1'b0;

    fill_random();
    run_sweep(-1, 1'b0, bc);
    check_full_by_loop("rand2");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
